// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Also provides the saturating 16-bit increment used by the optional statistics counters.
package regfile_pkg;

  localparam int REG_AW       = 5;
  localparam int ZERO_REG_IDX = 31;
  localparam int DATA_W       = 64;

  // Encoding of wr_sel: which requester's address/data feeds the register file.
  typedef enum logic {REQ_ALU = 1'b0, REQ_LD = 1'b1} wb_src_e;

  // The grant FSM state is the identity of the most recent winner.
  typedef enum logic {G0_LAST = 1'b0, G1_LAST = 1'b1} grant_state_e;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic inc);
    if (inc && (val != 16'hFFFF)) return val + 16'd1;
    return val;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational grant plus the last-winner state flop.
// Grants are suppressed while reset is asserted.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  output logic [1:0] grant
);

  grant_state_e state_q, state_d;

  always_comb begin
    grant   = 2'b00;
    state_d = state_q;
    if (reset) begin
      // Under contention the requester that did not win last time goes next.
      if (req_valid == 2'b11) grant = (state_q == G1_LAST) ? 2'b01 : 2'b10;
      else                    grant = req_valid;
      if (grant != 2'b00) state_d = grant[1] ? G1_LAST : G0_LAST;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= G1_LAST;
    else        state_q <= state_d;
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the register-file write port between the ALU (req0) and load unit (req1), one registered stage.
// Optional statistics counters are enabled by defining WPORT_STATS_EN.
module regfile_wport_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [9:0]        req_addr,
  input  logic [2*DATA_W-1:0] req_data,
  output logic [1:0]        req_ready,
`ifdef WPORT_STATS_EN
  output logic [15:0]       stat_grant0,
  output logic [15:0]       stat_grant1,
  output logic [15:0]       stat_conflict,
`endif
  output logic              wr_en,
  output logic              wr_sel,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  logic [1:0]        grant;
  logic              xfer;
  logic [4:0]        sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              wr_en_q, wr_en_d;
  wb_src_e           wr_sel_q, wr_sel_d;
  logic [4:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .grant     (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;
  assign sel_addr  = grant[1] ? req_addr[9:5] : req_addr[4:0];
  assign sel_data  = grant[1] ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];

  always_comb begin
    wr_en_d   = 1'b0;
    wr_sel_d  = wr_sel_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (xfer) begin
      // Writes to the hardwired-zero register are accepted but never reach the array.
      wr_en_d   = (sel_addr != 5'(ZERO_REG));
      wr_sel_d  = grant[1] ? REQ_LD : REQ_ALU;
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_q   <= 1'b0;
      wr_sel_q  <= REQ_ALU;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_sel  = wr_sel_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

`ifdef WPORT_STATS_EN
  logic [15:0] stat_grant0_q, stat_grant0_d;
  logic [15:0] stat_grant1_q, stat_grant1_d;
  logic [15:0] stat_conflict_q, stat_conflict_d;

  always_comb begin
    stat_grant0_d   = sat_inc16(stat_grant0_q, grant[0]);
    stat_grant1_d   = sat_inc16(stat_grant1_q, grant[1]);
    stat_conflict_d = sat_inc16(stat_conflict_q, reset && (req_valid == 2'b11));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_grant0_q   <= '0;
      stat_grant1_q   <= '0;
      stat_conflict_q <= '0;
    end else begin
      stat_grant0_q   <= stat_grant0_d;
      stat_grant1_q   <= stat_grant1_d;
      stat_conflict_q <= stat_conflict_d;
    end
  end

  assign stat_grant0   = stat_grant0_q;
  assign stat_grant1   = stat_grant1_q;
  assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter; statistics checks are compiled in with WPORT_STATS_EN.
module tb_regfile_wport_arbiter;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [9:0]    req_addr;
  logic [2*DW-1:0] req_data;
  logic [1:0]    req_ready;
  logic          wr_en;
  logic          wr_sel;
  logic [4:0]    wr_addr;
  logic [DW-1:0] wr_data;
`ifdef WPORT_STATS_EN
  logic [15:0]   stat_grant0, stat_grant1, stat_conflict;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wport_arbiter #(.DATA_W(DW), .ZERO_REG(31)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
`ifdef WPORT_STATS_EN
    .stat_grant0   (stat_grant0),
    .stat_grant1   (stat_grant1),
    .stat_conflict (stat_conflict),
`endif
    .wr_en         (wr_en),
    .wr_sel        (wr_sel),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 2'b00;
    req_addr  = '0;
    req_data  = '0;

    // Reset held low for three cycles; ready must stay low even with requests.
    tick();
    tick();
    req_valid = 2'b11;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    tick();
    req_valid = 2'b00;
    reset     = 1'b1;
    #1;
    chk("idle_wr_en", 64'(wr_en), 64'd0);
    chk("idle_wr_sel", 64'(wr_sel), 64'd0);
    chk("idle_wr_addr", 64'(wr_addr), 64'd0);
    chk("idle_wr_data", wr_data, 64'd0);
    chk("idle_ready", 64'(req_ready), 64'd0);

    // Single req0 write.
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd5};
    req_data  = {64'd0, 64'hA5};
    #1;
    chk("r0_ready", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b00;
    chk("r0_wr_en", 64'(wr_en), 64'd1);
    chk("r0_wr_sel", 64'(wr_sel), 64'd0);
    chk("r0_wr_addr", 64'(wr_addr), 64'd5);
    chk("r0_wr_data", wr_data, 64'hA5);
    tick();
    chk("hold_wr_en", 64'(wr_en), 64'd0);
    chk("hold_wr_addr", 64'(wr_addr), 64'd5);
    chk("hold_wr_data", wr_data, 64'hA5);

    // Single req1 write leaves req1 as last winner.
    req_valid = 2'b10;
    req_addr  = {5'd7, 5'd0};
    req_data  = {64'h77, 64'd0};
    #1;
    chk("r1_ready", 64'(req_ready), 64'b10);
    tick();
    req_valid = 2'b00;
    chk("r1_wr_en", 64'(wr_en), 64'd1);
    chk("r1_wr_sel", 64'(wr_sel), 64'd1);
    chk("r1_wr_addr", 64'(wr_addr), 64'd7);
    chk("r1_wr_data", wr_data, 64'h77);

    // Four contended cycles alternate 0,1,0,1.
    req_valid = 2'b11;
    req_addr  = {5'd2, 5'd1};
    req_data  = {64'h22, 64'h11};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready", 64'(req_ready), (i % 2 == 0) ? 64'b01 : 64'b10);
      tick();
      chk("rr_wr_en", 64'(wr_en), 64'd1);
      chk("rr_wr_addr", 64'(wr_addr), (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("rr_wr_sel", 64'(wr_sel), (i % 2 == 0) ? 64'd0 : 64'd1);
      chk("rr_wr_data", wr_data, (i % 2 == 0) ? 64'h11 : 64'h22);
    end

    // req1 writes the zero register: accepted, no write enable.
    req_valid = 2'b10;
    req_addr  = {5'd31, 5'd1};
    req_data  = {64'hDEAD, 64'h11};
    #1;
    chk("xzr_ready", 64'(req_ready), 64'b10);
    tick();
    req_valid = 2'b11;
    req_addr  = {5'd2, 5'd1};
    req_data  = {64'h22, 64'h11};
    chk("xzr_wr_en", 64'(wr_en), 64'd0);
    chk("xzr_wr_sel", 64'(wr_sel), 64'd1);
    chk("xzr_wr_addr", 64'(wr_addr), 64'd31);
    chk("xzr_wr_data", wr_data, 64'hDEAD);
    #1;
    chk("xzr_next_ready", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b00;
    chk("xzr_next_wr_en", 64'(wr_en), 64'd1);
    chk("xzr_next_addr", 64'(wr_addr), 64'd1);

    // Reset right after a req0 transfer drops the pending write.
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd9};
    req_data  = {64'd0, 64'h99};
    tick();
    req_valid = 2'b11;
    req_addr  = {5'd2, 5'd1};
    req_data  = {64'h22, 64'h11};
    chk("pre_rst_wr_en", 64'(wr_en), 64'd1);
    chk("pre_rst_addr", 64'(wr_addr), 64'd9);
    reset = 1'b0;
    #1;
    chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
    chk("mid_rst_addr", 64'(wr_addr), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b00;
    chk("post_rst_wr_en", 64'(wr_en), 64'd1);
    chk("post_rst_addr", 64'(wr_addr), 64'd1);

    // Three contended cycles then two req1-only cycles from a fresh reset.
    reset = 1'b0;
    tick();
    reset     = 1'b1;
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_rr_addr", 64'(wr_addr), (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("st_rr_wr_en", 64'(wr_en), 64'd1);
    end
    req_valid = 2'b10;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("st_r1_addr", 64'(wr_addr), 64'd2);
      chk("st_r1_sel", 64'(wr_sel), 64'd1);
    end
    req_valid = 2'b00;
    tick();
    chk("st_end_wr_en", 64'(wr_en), 64'd0);
    chk("st_end_addr", 64'(wr_addr), 64'd2);
`ifdef WPORT_STATS_EN
    chk("stat_grant0", 64'(stat_grant0), 64'd2);
    chk("stat_grant1", 64'(stat_grant1), 64'd3);
    chk("stat_conflict", 64'(stat_conflict), 64'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
